// File: rtl/veer_types.sv
// Shared type definitions for the DCCM initializer.
// Holds the state encoding used by lsu_dccm_initializer.
package veer_types;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    VERIFY = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } dccm_init_state_t;

endpackage

// File: rtl/lsu_dccm_init_chk.sv
// Read-back checker for the DCCM initializer.
// Tracks outstanding initializer reads in an RD_LAT-deep tag pipe, compares the
// returned word against INIT_PATTERN, and captures the byte address of the first
// mismatch.
// Ports:
//   clk, rst_l       clock, asynchronous active-low reset
//   clr              clear the sticky error flag and address (new pass)
//   rd_issue         a read is being issued this cycle
//   rd_addr          byte address of that read
//   rd_data          read return data, valid RD_LAT cycles after issue
//   pipe_pending     reads still in flight beyond the one being compared now
//   verify_err       sticky mismatch flag
//   verify_err_addr  byte address of the first mismatch
module lsu_dccm_init_chk #(
  parameter int                     DCCM_BITS    = 16,
  parameter int                     FDATA_WIDTH  = 39,
  parameter logic [FDATA_WIDTH-1:0] INIT_PATTERN = '0,
  parameter int                     RD_LAT       = 1
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   clr,
  input  logic                   rd_issue,
  input  logic [DCCM_BITS-1:0]   rd_addr,
  input  logic [FDATA_WIDTH-1:0] rd_data,
  output logic                   pipe_pending,
  output logic                   verify_err,
  output logic [DCCM_BITS-1:0]   verify_err_addr
);

  // The output stage is compared in the current cycle, so only the younger
  // stages count as still in flight.
  localparam logic [RD_LAT-1:0] PEND_MASK = {RD_LAT{1'b1}} >> 1;

  logic [RD_LAT-1:0]                vld_q, vld_d;
  logic [RD_LAT-1:0][DCCM_BITS-1:0] addr_q, addr_d;
  logic                             err_q, err_d;
  logic [DCCM_BITS-1:0]             err_addr_q, err_addr_d;
  logic                             mis;

  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    vld_d[0]  = rd_issue;
    addr_d[0] = rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  // Returns are compared regardless of lsu_busy; only initializer reads are tagged.
  assign mis = vld_q[RD_LAT-1] && (rd_data != INIT_PATTERN);

  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (mis) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = addr_q[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q      <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      vld_q      <= vld_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign pipe_pending    = |(vld_q & PEND_MASK);
  assign verify_err      = err_q;
  assign verify_err_addr = err_addr_q;

endmodule

// File: rtl/lsu_dccm_initializer.sv
// DCCM initializer: requester side of the DCCM port. Writes INIT_PATTERN into
// every word after reset (AUTO_START) or on start, yielding whenever the LSU
// owns the port. With RV_DCCM_INIT_VERIFY_EN defined it then reads every word
// back and flags the first mismatch; without it the read side ties to 0.
// Ports:
//   clk, rst_l                    clock, asynchronous active-low reset
//   start                         single-cycle (re)initialize request
//   lsu_busy                      LSU owns the DCCM port this cycle
//   dccm_wren, dccm_wr_addr,
//   dccm_wr_data                  write request
//   dccm_rden, dccm_rd_addr_lo/hi read request (verify build only)
//   dccm_rd_data_lo               read return data
//   init_busy, init_done          pass status
//   verify_err, verify_err_addr   sticky mismatch flag and first bad address
//
// state  | meaning
// IDLE   | after reset, waiting for auto start or start
// WRITE  | writing INIT_PATTERN to word cnt when the LSU is idle
// VERIFY | reading word cnt back when the LSU is idle
// DRAIN  | last read issued, waiting for in-flight returns
// DONE   | pass complete, init_done high, waiting for start
module lsu_dccm_initializer
  import veer_types::*;
#(
  parameter int                     DCCM_BITS    = 16,
  parameter int                     FDATA_WIDTH  = 39,
  parameter logic [FDATA_WIDTH-1:0] INIT_PATTERN = '0,
  parameter bit                     AUTO_START   = 1'b1,
  parameter int                     RD_LAT       = 1
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   start,
  input  logic                   lsu_busy,
  output logic                   dccm_wren,
  output logic                   dccm_rden,
  output logic [DCCM_BITS-1:0]   dccm_wr_addr,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]   dccm_rd_addr_hi,
  output logic [FDATA_WIDTH-1:0] dccm_wr_data,
  input  logic [FDATA_WIDTH-1:0] dccm_rd_data_lo,
  output logic                   init_busy,
  output logic                   init_done,
  output logic                   verify_err,
  output logic [DCCM_BITS-1:0]   verify_err_addr
);

  localparam int CNT_W = DCCM_BITS - 2;

  dccm_init_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             cnt_last;
  logic             wr_issue;
  logic             clr_pass;
`ifdef RV_DCCM_INIT_VERIFY_EN
  logic             rd_issue;
  logic             pipe_pending;
`endif

  assign cnt_last = &cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    wr_issue = 1'b0;
    clr_pass = 1'b0;
`ifdef RV_DCCM_INIT_VERIFY_EN
    rd_issue = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start || (AUTO_START && first_q)) begin
          state_d  = WRITE;
          cnt_d    = '0;
          clr_pass = 1'b1;
        end
      end
      WRITE: begin
        if (!lsu_busy) begin
          wr_issue = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_last) begin
`ifdef RV_DCCM_INIT_VERIFY_EN
            state_d = VERIFY;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef RV_DCCM_INIT_VERIFY_EN
      VERIFY: begin
        if (!lsu_busy) begin
          rd_issue = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_pending) state_d = DONE;
      end
`endif
      DONE: begin
        if (start) begin
          state_d  = WRITE;
          cnt_d    = '0;
          clr_pass = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // first_q marks the single cycle right after reset release for auto start.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Strobes are combinational from state and !lsu_busy so they never overlap
  // an LSU access.
  assign dccm_wren    = wr_issue;
  assign dccm_wr_addr = {cnt_q, 2'b00};
  assign dccm_wr_data = INIT_PATTERN;
  assign init_busy    = (state_q == WRITE) || (state_q == VERIFY) || (state_q == DRAIN);
  assign init_done    = (state_q == DONE);

`ifdef RV_DCCM_INIT_VERIFY_EN
  assign dccm_rden       = rd_issue;
  assign dccm_rd_addr_lo = {cnt_q, 2'b00};
  assign dccm_rd_addr_hi = {cnt_q, 2'b00};

  lsu_dccm_init_chk #(
    .DCCM_BITS   (DCCM_BITS),
    .FDATA_WIDTH (FDATA_WIDTH),
    .INIT_PATTERN(INIT_PATTERN),
    .RD_LAT      (RD_LAT)
  ) u_chk (
    .clk            (clk),
    .rst_l          (rst_l),
    .clr            (clr_pass),
    .rd_issue       (rd_issue),
    .rd_addr        ({cnt_q, 2'b00}),
    .rd_data        (dccm_rd_data_lo),
    .pipe_pending   (pipe_pending),
    .verify_err     (verify_err),
    .verify_err_addr(verify_err_addr)
  );
`else
  logic unused_rd_side;

  assign dccm_rden       = 1'b0;
  assign dccm_rd_addr_lo = '0;
  assign dccm_rd_addr_hi = '0;
  assign verify_err      = 1'b0;
  assign verify_err_addr = '0;
  assign unused_rd_side  = (^dccm_rd_data_lo) ^ clr_pass ^ (RD_LAT > 0);
`endif

endmodule

// File: tb/tb_lsu_dccm_initializer.sv
// Scoreboard bench for lsu_dccm_initializer (DCCM_BITS=6, RD_LAT=1, AUTO_START=1).
// Expected write/read addresses are queued per pass; a negedge monitor pops and
// compares whenever the DUT strobes the port. Define RV_DCCM_INIT_VERIFY_EN to
// exercise the verify build.
module tb_lsu_dccm_initializer;

  localparam int DB = 6;
  localparam int FW = 39;
  localparam int RL = 1;
  localparam int NW = 16;
  localparam logic [FW-1:0] PAT = '0;
`ifdef RV_DCCM_INIT_VERIFY_EN
  localparam int VCYC = NW + RL;
`else
  localparam int VCYC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_l = 1'b1;
  logic          start = 1'b0;
  logic          lsu_busy = 1'b0;
  logic          dccm_wren, dccm_rden;
  logic [DB-1:0] dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [FW-1:0] dccm_wr_data;
  logic [FW-1:0] rd_data = '0;
  logic          init_busy, init_done, verify_err;
  logic [DB-1:0] verify_err_addr;

  logic [FW-1:0] mem [NW];
  logic          corrupt = 1'b0;
  int            checks = 0;
  int            errors = 0;
  logic [DB-1:0] exp_wr_q[$];
  logic [DB-1:0] exp_rd_q[$];

  always #5 clk = ~clk;

  lsu_dccm_initializer #(
    .DCCM_BITS   (DB),
    .FDATA_WIDTH (FW),
    .INIT_PATTERN(PAT),
    .AUTO_START  (1'b1),
    .RD_LAT      (RL)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .start          (start),
    .lsu_busy       (lsu_busy),
    .dccm_wren      (dccm_wren),
    .dccm_rden      (dccm_rden),
    .dccm_wr_addr   (dccm_wr_addr),
    .dccm_rd_addr_lo(dccm_rd_addr_lo),
    .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_wr_data   (dccm_wr_data),
    .dccm_rd_data_lo(rd_data),
    .init_busy      (init_busy),
    .init_done      (init_done),
    .verify_err     (verify_err),
    .verify_err_addr(verify_err_addr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Memory model; corrupt mode damages the words at 0x20 and 0x30.
  always @(posedge clk) begin
    if (dccm_wren)
      mem[dccm_wr_addr[5:2]] <= (corrupt && (dccm_wr_addr == 6'h20 || dccm_wr_addr == 6'h30))
                                ? ~dccm_wr_data : dccm_wr_data;
    if (dccm_rden) rd_data <= mem[dccm_rd_addr_lo[5:2]];
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_l) begin
      if (lsu_busy) chk("yield_to_lsu", 64'({dccm_wren, dccm_rden}), 64'd0);
      if (dccm_wren) begin
        chk("wr_expected", 64'(exp_wr_q.size() > 0), 64'd1);
        if (exp_wr_q.size() > 0) begin
          logic [DB-1:0] e;
          e = exp_wr_q.pop_front();
          chk("wr_addr_data", 64'({dccm_wr_data, dccm_wr_addr}), 64'({PAT, e}));
        end
      end
`ifdef RV_DCCM_INIT_VERIFY_EN
      if (dccm_rden) begin
        chk("rd_expected", 64'(exp_rd_q.size() > 0), 64'd1);
        if (exp_rd_q.size() > 0) begin
          logic [DB-1:0] e;
          e = exp_rd_q.pop_front();
          chk("rd_addr_lo_hi", 64'({dccm_rd_addr_lo, dccm_rd_addr_hi}), 64'({e, e}));
        end
      end
`else
      chk("rd_side_tied", 64'({dccm_rden, dccm_rd_addr_lo, dccm_rd_addr_hi}), 64'd0);
`endif
    end
  end

  task automatic push_pass();
    for (int i = 0; i < NW; i++) begin
      exp_wr_q.push_back(DB'(i * 4));
`ifdef RV_DCCM_INIT_VERIFY_EN
      exp_rd_q.push_back(DB'(i * 4));
`endif
    end
  endtask

  // Counts rising edges until init_done, bounded.
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    while (!init_done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    chk(name, 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 64'({dccm_wren, dccm_rden, dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi,
                   init_busy, init_done, verify_err, verify_err_addr}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = PAT;
    #1 rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");

    // Auto start after reset release, no stalls
    push_pass();
    rst_l = 1'b1;
    wait_done("done_after_reset", NW + 1 + VCYC);
    chk("verify_err_clean", 64'(verify_err), 64'd0);
    chk("init_busy_low_in_done", 64'(init_busy), 64'd0);
    check_drained("pass1_drained");

    // Start in DONE, 3-cycle LSU stall at cnt=5
    push_pass();
    pulse_start();
    chk("start_clears_done", 64'({init_done, init_busy}), 64'b01);
    fork
      wait_done("done_with_stall", NW + 3 + VCYC);
      begin
        repeat (5) @(posedge clk);
        #1 lsu_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 lsu_busy = 1'b0;
      end
    join
    check_drained("pass2_drained");

    // Start at cnt=7 ignored; words 0x20 and 0x30 corrupted
    corrupt = 1'b1;
    push_pass();
    pulse_start();
    fork
      wait_done("done_start_ignored", NW + VCYC);
      begin
        repeat (7) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    check_drained("pass3_drained");
`ifdef RV_DCCM_INIT_VERIFY_EN
    chk("verify_err_set", 64'({verify_err, verify_err_addr}), 64'({1'b1, 6'h20}));
`else
    chk("verify_err_tied", 64'({verify_err, verify_err_addr}), 64'd0);
`endif
    corrupt = 1'b0;

    // Start in DONE clears error; reset asserted at cnt=9
    push_pass();
    pulse_start();
    chk("start_clears_err", 64'({init_done, verify_err, verify_err_addr}), 64'd0);
    repeat (9) @(posedge clk);
    #1;
    chk("wr_addr_at_cnt9", 64'(dccm_wr_addr), 64'h24);
    rst_l = 1'b0;
    #1;
    check_all_zero("mid_pass_reset_outputs");
    exp_wr_q.delete();
    exp_rd_q.delete();
    push_pass();
    @(posedge clk);
    #1 rst_l = 1'b1;
    wait_done("done_after_mid_reset", NW + 1 + VCYC);
    chk("verify_err_after_restart", 64'(verify_err), 64'd0);
    check_drained("pass4_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
